// File: rtl/seg_scan_scheduler.sv
// seg_scan_scheduler: multiplexes one active-low 7-segment cathode bus across
// eight active-low digit anodes. Each digit gets a DRIVE slot of TICK_DIV cycles,
// followed by a GUARD interval of GUARD all-off cycles. A new display value is
// staged in a shadow register and applied only at frame boundaries (entry to the
// digit-0 slot), so a frame is never torn.
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous active-low reset
//   data_in[31:0]  display value, nibble k shown on digit k
//   data_we        one-cycle strobe, captures data_in into the shadow register
//   dig_en[7:0]    per-digit enable
//   lzs            leading-zero suppression enable
//   a..g           segment cathodes, active-low, registered
//   aa7..aa0       digit anodes, active-low, registered, at most one low
//   frame_start    one-cycle pulse on the first cycle of the digit-0 slot
//   update_pending shadow holds data not yet applied
module seg_scan_scheduler #(
    parameter int unsigned TICK_DIV = 100000,
    parameter int unsigned GUARD    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data_in,
    input  logic        data_we,
    input  logic [7:0]  dig_en,
    input  logic        lzs,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        e,
    output logic        f,
    output logic        g,
    output logic        aa7,
    output logic        aa6,
    output logic        aa5,
    output logic        aa4,
    output logic        aa3,
    output logic        aa2,
    output logic        aa1,
    output logic        aa0,
    output logic        frame_start,
    output logic        update_pending
);

    localparam int unsigned CNT_MAX = (TICK_DIV > GUARD) ? TICK_DIV : GUARD;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SEG_W   = 7;
    localparam int unsigned DIG_N   = 8;
    localparam int unsigned IDX_W   = 3;

    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((GUARD == 0) ? 0 : GUARD - 1);

    typedef enum logic {
        S_DRIVE = 1'b0,
        S_GUARD = 1'b1
    } state_t;

    state_t              state_q, state_nx;
    logic [IDX_W-1:0]    idx_q, idx_nx;
    logic [CNT_W-1:0]    cnt_q, cnt_nx;
    logic                advance_c;

    logic [DATA_W-1:0]   shadow_q, shadow_nx;
    logic [DATA_W-1:0]   active_q, active_nx;
    logic                pending_q, pending_nx;

    logic [SEG_W-1:0]    seg_q, seg_nx;
    logic [DIG_N-1:0]    an_q, an_nx;
    logic                fs_q, fs_nx;

    logic                boundary_c;
    logic [3:0]          nib_c;
    logic                visible_c;

    // Standard hex glyphs, {a,b,c,d,e,f,g}, 0 = lit.
    function automatic logic [SEG_W-1:0] hex_decode(input logic [3:0] n);
        logic [SEG_W-1:0] s;
        case (n)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001111;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0000100;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b1100000;
            4'hC:    s = 7'b0110001;
            4'hD:    s = 7'b1000010;
            4'hE:    s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    // State register: slot state, digit index and shared slot counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_GUARD;
            idx_q   <= IDX_W'(7);
            cnt_q   <= '0;
        end else begin
            state_q <= state_nx;
            idx_q   <= idx_nx;
            cnt_q   <= cnt_nx;
        end
    end

    // Next-state: DRIVE for TICK_DIV cycles, GUARD for GUARD cycles (skipped when 0).
    always_comb begin
        state_nx  = state_q;
        idx_nx    = idx_q;
        cnt_nx    = cnt_q + CNT_W'(1);
        advance_c = 1'b0;
        case (state_q)
            S_DRIVE: begin
                if (cnt_q == DRIVE_LAST) begin
                    cnt_nx = '0;
                    if (GUARD == 0) begin
                        idx_nx    = idx_q + IDX_W'(1);
                        advance_c = 1'b1;
                    end else begin
                        state_nx = S_GUARD;
                    end
                end
            end
            default: begin
                if ((GUARD == 0) || (cnt_q == GUARD_LAST)) begin
                    cnt_nx    = '0;
                    state_nx  = S_DRIVE;
                    idx_nx    = idx_q + IDX_W'(1);
                    advance_c = 1'b1;
                end
            end
        endcase
    end

    // Output/datapath next values, derived from the next state so that anodes and
    // segments change on the same edge as the slot transition.
    always_comb begin
        shadow_nx  = shadow_q;
        active_nx  = active_q;
        pending_nx = pending_q;
        seg_nx     = '1;
        an_nx      = '1;
        fs_nx      = 1'b0;
        nib_c      = 4'h0;
        visible_c  = 1'b0;
        boundary_c = advance_c && (idx_nx == IDX_W'(0));

        // A write landing on the boundary edge bypasses the shadow.
        if (boundary_c) begin
            if (data_we) begin
                shadow_nx  = data_in;
                active_nx  = data_in;
                pending_nx = 1'b0;
            end else if (pending_q) begin
                active_nx  = shadow_q;
                pending_nx = 1'b0;
            end
        end else if (data_we) begin
            shadow_nx  = data_in;
            pending_nx = 1'b1;
        end

        if (state_nx == S_DRIVE) begin
            nib_c     = active_nx[{idx_nx, 2'b00} +: 4];
            // Suppressed: this nibble and every higher nibble are zero.
            visible_c = dig_en[idx_nx] &&
                        !(lzs && (idx_nx != IDX_W'(0)) &&
                          ((active_nx >> {idx_nx, 2'b00}) == DATA_W'(0)));
            if (visible_c) begin
                seg_nx        = hex_decode(nib_c);
                an_nx[idx_nx] = 1'b0;
            end
        end

        fs_nx = boundary_c;
    end

    // Registered datapath and outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
            seg_q     <= '1;
            an_q      <= '1;
            fs_q      <= 1'b0;
        end else begin
            shadow_q  <= shadow_nx;
            active_q  <= active_nx;
            pending_q <= pending_nx;
            seg_q     <= seg_nx;
            an_q      <= an_nx;
            fs_q      <= fs_nx;
        end
    end

    assign {a, b, c, d, e, f, g}                       = seg_q;
    assign {aa7, aa6, aa5, aa4, aa3, aa2, aa1, aa0}    = an_q;
    assign frame_start                                 = fs_q;
    assign update_pending                              = pending_q;

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Testbench for seg_scan_scheduler (TICK_DIV=4, GUARD=2). A timeline model
// derives each cycle's expected outputs from the cycle count since reset and
// the frame-boundary update rules, pushes them to a queue, and a monitor pops
// and compares them against the DUT on the falling edge.
module tb_seg_scan_scheduler;

    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned GUARD    = 2;
    localparam int          SLOT     = TICK_DIV + GUARD;
    localparam int          FRAME    = 8 * SLOT;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] data_in;
    logic        data_we;
    logic [7:0]  dig_en;
    logic        lzs;
    logic        a, b, c, d, e, f, g;
    logic        aa7, aa6, aa5, aa4, aa3, aa2, aa1, aa0;
    logic        frame_start, update_pending;

    always #5 clk = ~clk;

    seg_scan_scheduler #(.TICK_DIV(TICK_DIV), .GUARD(GUARD)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .data_we(data_we),
        .dig_en(dig_en), .lzs(lzs),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
        .aa7(aa7), .aa6(aa6), .aa5(aa5), .aa4(aa4),
        .aa3(aa3), .aa2(aa2), .aa1(aa1), .aa0(aa0),
        .frame_start(frame_start), .update_pending(update_pending)
    );

    logic [7:0] an_w;
    logic [6:0] seg_w;
    assign an_w  = {aa7, aa6, aa5, aa4, aa3, aa2, aa1, aa0};
    assign seg_w = {a, b, c, d, e, f, g};

    logic [6:0] glyph [0:15] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       fs;
        logic       up;
        logic       drv;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int passed = 0;
    int fails_shown = 0;

    // Model state: time since last reset edge, staged and displayed values.
    int          k = 0;
    logic [31:0] m_shadow = '0;
    logic [31:0] m_active = '0;
    logic        m_pending = 1'b0;
    int          m_slot = -1;
    int          m_pos  = -1;

    always @(posedge clk) begin : model
        exp_t ex;
        int   rel;
        int   dg;
        bit   boundary;
        bit   vis;
        ex = '{an: 8'hFF, seg: 7'h7F, fs: 1'b0, up: 1'b0, drv: 1'b0};
        m_slot = -1;
        m_pos  = -1;
        if (!reset) begin
            k = 0;
            m_shadow = '0;
            m_active = '0;
            m_pending = 1'b0;
        end else begin
            k = k + 1;
            boundary = (k >= GUARD) && (((k - GUARD) % FRAME) == 0);
            if (boundary) begin
                if (data_we) begin
                    m_shadow  = data_in;
                    m_active  = data_in;
                    m_pending = 1'b0;
                end else if (m_pending) begin
                    m_active  = m_shadow;
                    m_pending = 1'b0;
                end
            end else if (data_we) begin
                m_shadow  = data_in;
                m_pending = 1'b1;
            end
            ex.up = m_pending;
            if (k >= GUARD) begin
                rel    = k - GUARD;
                m_pos  = rel % SLOT;
                dg     = (rel / SLOT) % 8;
                m_slot = dg;
                ex.fs  = boundary;
                if (m_pos < TICK_DIV) begin
                    ex.drv = 1'b1;
                    vis = dig_en[dg] &&
                          !(lzs && dg > 0 && ((m_active >> (4 * dg)) == 32'd0));
                    if (vis) begin
                        ex.an[dg] = 1'b0;
                        ex.seg    = glyph[m_active[4*dg +: 4]];
                    end
                end
            end
        end
        exp_q.push_back(ex);
    end

    always @(negedge clk) begin : monitor
        exp_t ex;
        bit   ok_rule;
        if (exp_q.size() > 0) begin
            ex = exp_q.pop_front();
            checks++;
            if ({an_w, seg_w, frame_start, update_pending} ===
                {ex.an, ex.seg, ex.fs, ex.up}) begin
                passed++;
            end else if (fails_shown < 40) begin
                fails_shown++;
                $display("FAIL outputs t=%0t k=%0d: got an=%b seg=%b fs=%b up=%b, want an=%b seg=%b fs=%b up=%b",
                         $time, k, an_w, seg_w, frame_start, update_pending,
                         ex.an, ex.seg, ex.fs, ex.up);
            end
            checks++;
            ok_rule = ($countones(~an_w) <= 1) && (ex.drv || an_w == 8'hFF);
            if (ok_rule) begin
                passed++;
            end else if (fails_shown < 40) begin
                fails_shown++;
                $display("FAIL anode_rule t=%0t: got an=%b, want at most one low and none in guard (guard=%0b)",
                         $time, an_w, !ex.drv);
            end
        end
    end

    task automatic write_val(input logic [31:0] v);
        data_in = v;
        data_we = 1'b1;
        @(negedge clk);
        data_we = 1'b0;
    endtask

    task automatic wait_pos(input int dg, input int p);
        int n;
        n = 0;
        while (!(m_slot == dg && m_pos == p) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            $display("FAIL wait_pos: slot %0d pos %0d not reached, got slot %0d pos %0d",
                     dg, p, m_slot, m_pos);
        end
    endtask

    initial begin
        int sh;
        reset   = 1'b0;
        data_in = '0;
        data_we = 1'b0;
        dig_en  = 8'hFF;
        lzs     = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Startup, no writes.
        repeat (2 * FRAME) @(negedge clk);

        // Mid-frame write during digit 3, applied at the next frame.
        wait_pos(3, 1);
        write_val(32'h8765_43F1);
        repeat (FRAME + 8) @(negedge clk);

        // Two writes in one frame: last wins.
        wait_pos(2, 0);
        write_val(32'h1111_1111);
        wait_pos(5, 0);
        write_val(32'h2222_2222);
        repeat (FRAME + 8) @(negedge clk);

        // Write on the exact boundary edge.
        wait_pos(7, 5);
        write_val(32'hA5C3_9E0B);
        repeat (FRAME) @(negedge clk);

        // Leading-zero suppression.
        lzs = 1'b1;
        write_val(32'h0000_0105);
        repeat (2 * FRAME) @(negedge clk);
        lzs = 1'b0;
        repeat (FRAME) @(negedge clk);
        lzs = 1'b1;
        write_val(32'h0000_0000);
        repeat (2 * FRAME) @(negedge clk);

        // Digit enable, then reset during the digit-2 DRIVE.
        lzs = 1'b0;
        write_val(32'h9ABC_DEF7);
        dig_en = 8'b0000_0101;
        repeat (2 * FRAME) @(negedge clk);
        wait_pos(2, 1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (FRAME + 10) @(negedge clk);
        dig_en = 8'hFF;

        // Randomized traffic.
        repeat (1500) begin
            @(negedge clk);
            data_we = ($urandom_range(0, 7) == 0);
            sh = $urandom_range(0, 8) * 4;
            data_in = (sh == 32) ? 32'd0 : ($urandom >> sh);
            if ($urandom_range(0, 63) == 0) dig_en = 8'($urandom);
            if ($urandom_range(0, 31) == 0) lzs = 1'($urandom);
            reset = ($urandom_range(0, 399) != 0);
        end
        data_we = 1'b0;
        reset   = 1'b1;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/seg_scan_scheduler.md
Name: seg_scan_scheduler

Overview:
- Time-shares the single 7-segment cathode bus (a..g) among the eight digits of the board display.
- Drives the active-low anodes aa7..aa0, one digit at a time, with a blanking guard interval between digits to prevent ghosting.
- Accepts a 32-bit hex value (8 nibbles) from the counter datapath and applies it only at frame boundaries, so a frame is never torn.

Parameters:
- TICK_DIV, 100000: clk cycles each digit is driven per slot; legal range ≥1.
- GUARD, 16: all-off clk cycles between slots; 0 means no guard state.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- data_in  in  32  display value; nibble k is shown on digit k (digit 0 = data_in[3:0]).
- data_we  in  1  one-cycle write strobe; captures data_in into the shadow register.
- dig_en  in  8  per-digit enable; 0 keeps that digit's anode off during its slot.
- lzs  in  1  leading-zero suppression enable.
- a,b,c,d,e,f,g  out  1 each  segment cathodes, active-low, registered.
- aa7..aa0  out  1 each  digit anodes, active-low, registered; at most one low at any time.
- frame_start  out  1  one-cycle pulse on entry to the digit-0 slot.
- update_pending  out  1  shadow holds data not yet applied.

Behaviour:
- Reset (reset=0 at an edge):
  - All anodes = 1; all segments = 1; frame_start = 0; update_pending = 0.
  - Shadow = 0; active = 0; idx = 7; state = GUARD; cnt = 0.
  - Reset asserted mid-slot takes effect at the next edge, with no partial slot continuing.
- FSM states:
  - DRIVE: held for TICK_DIV cycles, with cnt running 0..TICK_DIV-1. Then go to GUARD, or, if GUARD = 0, go directly to DRIVE for the next idx.
  - GUARD: held for GUARD cycles. All anodes are 1 and all segments are 1. Then go to DRIVE with idx = (idx+1) mod 8.
- Slot and frame timing:
  - Slot period = TICK_DIV + GUARD cycles; frame = 8 slots.
  - After reset release, the first DRIVE (idx 0) begins after GUARD cycles, or on the first edge if GUARD = 0.
- Frame boundary (transition into DRIVE with idx = 0):
  - frame_start = 1 for exactly that first DRIVE cycle.
  - If update_pending, active <= shadow and update_pending <= 0.
- Shadow writes:
  - data_we=1 sets shadow <= data_in and update_pending <= 1.
  - Multiple writes within a frame: the last write wins.
  - data_we on the same edge as the boundary transition: active <= data_in directly; update_pending stays 0.
- In DRIVE for digit k:
  - aa[k] = 0 if the digit is visible, otherwise 1; all other anodes are 1.
  - Segments = hex decode of active nibble k if visible, else all 1.
  - Visible means dig_en[k] = 1 and the digit is not suppressed.
- Suppression:
  - With lzs = 1, digit k > 0 is suppressed when nibbles k..7 are all zero.
  - Digit 0 is never suppressed.
  - Disabled digits still consume their slot, so timing stays uniform.
- Decode ({a,b,c,d,e,f,g}, 0 = lit), standard hex glyphs:
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100, 5 = 0100100, 6 = 0100000, 7 = 0001111.
  - 8 = 0000000, 9 = 0000100, A = 0001000, b = 1100000, C = 0110001, d = 1000010, E = 0110000, F = 0111000.
- Outputs change only on clk edges. Segment and anode values are updated on the same edge as the corresponding state change, giving zero skew between them.

Test Plan (TICK_DIV=4, GUARD=2, slot = 6 cycles, frame = 48):
- Reset/startup: release reset, no writes.
  - Required: anodes all 1 for 2 cycles.
  - Then aa0 = 0 with segments 0000001 for 4 cycles, and frame_start pulses once on that first cycle.
  - Then 2 all-off cycles, then aa1 = 0. The pattern repeats every 48 cycles.
- Write mid-frame: write data_in = 32'h8765_43F1 during the digit-3 slot.
  - Required: update_pending = 1 and the display is unchanged until the next frame_start.
  - Then digit 0 = 1001111, digit 1 = 0111000 ("F"), digit 7 = 0000000 ("8"); update_pending = 0.
- Boundary collision and last-wins:
  - Two writes (0x11111111, then 0x22222222) in one frame: the frame applies 0x22222222.
  - A write on the exact boundary edge shows the new value in that same digit-0 slot.
- Leading-zero suppression: data = 32'h0000_0105, lzs = 1.
  - Required: digits 7..3 have their anodes held at 1 for their whole slots; digits 2, 1, 0 show 1, 0, 5.
  - With lzs = 0, all 8 digits light.
  - With data = 0 and lzs = 1, only digit 0 lights and shows "0".
- Digit enable plus reset mid-slot:
  - dig_en = 8'b0000_0101: only aa0 and aa2 ever go low, and the frame period stays 48.
  - reset = 0 during the digit-2 DRIVE: at the next edge all anodes and segments = 1 and active = 0; restart follows the startup scenario.
- Throughout: assertion that at most one anode is low in every cycle, and that anodes are never low during GUARD.
